aurora_link_supervisor: RTL
===========================

Name: aurora_link_supervisor

Overview:
Bring-up and recovery controller for one aurora_core_wrap lane, running in the init_clk domain.
- Drives the wrapper's ext_reset and power_down.
- Synchronizes lane_up, channel_up and hard_err, and enforces timeouts on lane and channel bring-up.
- Requires a stable-channel qualification window before declaring link_ok.
- Retries with a bounded count; latches a failed state when retries are exhausted.

Parameters:
RESET_HOLD, 128, init_clk cycles ext_reset is held per reset attempt (>=2)
LANE_TIMEOUT, 1000000, cycles allowed in WAIT_LANE for lane_up
CHAN_TIMEOUT, 1000000, cycles allowed in WAIT_CHAN for channel_up
STABLE_CYCLES, 4096, consecutive cycles of channel_up required before UP
HERR_PERSIST, 8, consecutive synchronized hard_err cycles that force a retry
MAX_RETRY, 7, retries before FAIL (1..15)
TW, 24, timer width; every timing parameter must be < 2^TW

Ports:
init_clk  in  1  sole clock
aresetn  in  1  asynchronous active-low reset
enable  in  1  init_clk domain; 1 = run link, 0 = hold in IDLE
force_reset  in  1  single-cycle request: restart bring-up and clear retries
lane_up  in  1  from wrapper, user_clk domain, 2-flop synchronized
channel_up  in  1  from wrapper, user_clk domain, 2-flop synchronized
hard_err  in  1  from wrapper, user_clk domain, 2-flop synchronized
ext_reset  out  1  to wrapper ext_reset
power_down  out  1  to wrapper power_down
link_ok  out  1  state == UP
link_failed  out  1  state == FAIL
retry_count  out  4  retries used in the current bring-up
reset_count  out  16  total reset attempts since aresetn, saturating at 16'hFFFF
state  out  3  IDLE=0 RESET=1 WAIT_LANE=2 WAIT_CHAN=3 STABLE=4 UP=5 FAIL=6

Behaviour:
- Outputs and reset:
  - All outputs are registered.
  - While aresetn=0: state IDLE, ext_reset=1, power_down=1, link_ok=0, link_failed=0, retry_count=0, reset_count=0.
  - Timer, hard_err run counter and synchronizers clear to 0.
- Synchronizers: the three link inputs pass through 2 flops (suffix _s). Internal decisions see each input 2 cycles after its change at the port.
- Output decode:
  - ext_reset=1 in IDLE, RESET and FAIL; 0 otherwise.
  - power_down=1 only in IDLE.
  - ext_reset and power_down change on the same edge as state.
- Priority each cycle (highest first):
  1. enable=0 -> IDLE. retry_count cleared; reset_count held.
  2. force_reset=1 (enable=1) -> RESET. retry_count=0, reset_count+1, timer=0.
  3. Per-state transitions below.
- IDLE: enable=1 -> RESET, reset_count+1, timer=0.
- RESET: timer increments each cycle; at timer==RESET_HOLD-1 -> WAIT_LANE, timer=0. ext_reset is therefore high for exactly RESET_HOLD cycles.
- WAIT_LANE:
  - lane_up_s -> WAIT_CHAN, timer=0.
  - Otherwise timer==LANE_TIMEOUT-1 -> RETRY.
  - lane_up_s wins over a same-cycle timeout.
- WAIT_CHAN:
  - channel_up_s -> STABLE, timer=0.
  - Otherwise lane_up_s=0 or timer==CHAN_TIMEOUT-1 -> RETRY.
- STABLE:
  - channel_up_s=0 or hard_err run==HERR_PERSIST -> RETRY.
  - Otherwise timer==STABLE_CYCLES-1 -> UP, retry_count=0.
- UP: channel_up_s=0 or hard_err run==HERR_PERSIST -> RETRY.
- FAIL: hold ext_reset=1 and link_failed=1. Exit only by enable=0 or force_reset.
- RETRY (an action, not a state):
  - If retry_count==MAX_RETRY -> FAIL.
  - Else retry_count+1, reset_count+1 (saturating), timer=0 -> RESET.
- hard_err run counter:
  - Increments while hard_err_s=1 in STABLE or UP; clears on any cycle hard_err_s=0 or in any other state.
  - Saturates at HERR_PERSIST.
  - The triggering cycle moves to RESET on the next edge.
- Timer: TW bits. It never wraps, because every state exits at or before its limit.
- Fixed latency: lane_up port edge -> WAIT_CHAN state is 3 cycles (2 synchronizer + 1 state register).

Test Plan:
1. Params RESET_HOLD=4, STABLE_CYCLES=8. Release aresetn, enable=1, lane_up high at cycle 10, channel_up at cycle 12 -> ext_reset high exactly 4 cycles, state reaches UP and link_ok=1 at channel_up+2+8 cycles, reset_count=1, retry_count=0.
2. LANE_TIMEOUT=16, MAX_RETRY=2, lane_up stuck low -> three ext_reset pulses (reset_count=3), then state=FAIL, link_failed=1, ext_reset=1 held; a force_reset pulse -> RESET, retry_count=0, reset_count=4.
3. In UP, drop channel_up for 1 cycle -> RETRY taken 2 cycles later, link_ok falls, retry_count=1, ext_reset reasserted 4 cycles.
4. In UP, hard_err high 7 cycles then low -> stays UP; hard_err high 8 consecutive cycles (HERR_PERSIST=8) -> RESET, retry_count=1.
5. Deassert enable mid-WAIT_CHAN, and separately assert aresetn=0 mid-STABLE -> next cycle IDLE, power_down=1, ext_reset=1. aresetn clears reset_count to 0; enable=0 preserves it.
6. Same-cycle lane_up_s and LANE_TIMEOUT expiry -> WAIT_CHAN, no retry. Same-cycle force_reset and enable=0 -> IDLE.

Source files
------------

// File: rtl/aurora_link_supervisor_if.sv
// Control, status and wrapper-facing signals of the aurora link supervisor.
// Master drives the requests and lane status; slave is the supervisor itself.
interface aurora_link_supervisor_if;
   logic        enable;
   logic        force_reset;
   logic        lane_up;
   logic        channel_up;
   logic        hard_err;
   logic        ext_reset;
   logic        power_down;
   logic        link_ok;
   logic        link_failed;
   logic [3:0]  retry_count;
   logic [15:0] reset_count;
   logic [2:0]  state;

   modport master (
      output enable, force_reset, lane_up, channel_up, hard_err,
      input  ext_reset, power_down, link_ok, link_failed,
      input  retry_count, reset_count, state
   );

   modport slave (
      input  enable, force_reset, lane_up, channel_up, hard_err,
      output ext_reset, power_down, link_ok, link_failed,
      output retry_count, reset_count, state
   );
endinterface

// File: rtl/aurora_link_supervisor.sv
// Bring-up / recovery controller for one aurora lane (init_clk domain).
// Sequences ext_reset, qualifies channel stability, retries, latches failure.
module aurora_link_supervisor #(
   parameter int RESET_HOLD    = 128,
   parameter int LANE_TIMEOUT  = 1000000,
   parameter int CHAN_TIMEOUT  = 1000000,
   parameter int STABLE_CYCLES = 4096,
   parameter int HERR_PERSIST  = 8,
   parameter int MAX_RETRY     = 7,
   parameter int TW            = 24
) (
   input logic                      init_clk,
   input logic                      aresetn,
   aurora_link_supervisor_if.slave  lnk
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RESET  = 3'd1;
   localparam logic [2:0] S_WLANE  = 3'd2;
   localparam logic [2:0] S_WCHAN  = 3'd3;
   localparam logic [2:0] S_STABLE = 3'd4;
   localparam logic [2:0] S_UP     = 3'd5;
   localparam logic [2:0] S_FAIL   = 3'd6;

   localparam int HW = $clog2(HERR_PERSIST + 1);

   localparam logic [TW-1:0] RH_END = TW'(RESET_HOLD - 1);
   localparam logic [TW-1:0] LT_END = TW'(LANE_TIMEOUT - 1);
   localparam logic [TW-1:0] CT_END = TW'(CHAN_TIMEOUT - 1);
   localparam logic [TW-1:0] SC_END = TW'(STABLE_CYCLES - 1);
   localparam logic [HW-1:0] HP_MAX = HW'(HERR_PERSIST);
   localparam logic [3:0]    RT_MAX = 4'(MAX_RETRY);

   logic [1:0]    lane_q, chan_q, herr_q;
   logic          lane_up_s, channel_up_s, hard_err_s;
   logic [2:0]    st, st_n;
   logic [TW-1:0] tmr, tmr_n;
   logic [3:0]    rty, rty_n;
   logic [15:0]   rcnt, rcnt_n;
   logic [HW-1:0] herr_run, herr_run_n;
   logic          do_retry, bump;
   logic          ext_reset_q, power_down_q, link_ok_q, link_failed_q;
   logic          herr_hit;

   assign lane_up_s    = lane_q[1];
   assign channel_up_s = chan_q[1];
   assign hard_err_s   = herr_q[1];
   assign herr_hit     = (herr_run == HP_MAX);

   // Two-flop synchronizers for the user_clk-domain status inputs.
   always_ff @(posedge init_clk or negedge aresetn) begin
      if (!aresetn) begin
         lane_q <= '0;
         chan_q <= '0;
         herr_q <= '0;
      end else begin
         lane_q <= {lane_q[0], lnk.lane_up};
         chan_q <= {chan_q[0], lnk.channel_up};
         herr_q <= {herr_q[0], lnk.hard_err};
      end
   end

   // Next-state, timer and counter decisions; retry is an action folded in last.
   always_comb begin
      st_n     = st;
      tmr_n    = tmr;
      rty_n    = rty;
      rcnt_n   = rcnt;
      do_retry = 1'b0;
      bump     = 1'b0;
      if (!lnk.enable) begin
         st_n  = S_IDLE;
         rty_n = '0;
         tmr_n = '0;
      end else if (lnk.force_reset) begin
         st_n  = S_RESET;
         rty_n = '0;
         tmr_n = '0;
         bump  = 1'b1;
      end else begin
         case (st)
            S_IDLE: begin
               st_n  = S_RESET;
               tmr_n = '0;
               bump  = 1'b1;
            end
            S_RESET: begin
               if (tmr == RH_END) begin
                  st_n  = S_WLANE;
                  tmr_n = '0;
               end else begin
                  tmr_n = tmr + TW'(1);
               end
            end
            S_WLANE: begin
               if (lane_up_s) begin
                  st_n  = S_WCHAN;
                  tmr_n = '0;
               end else if (tmr == LT_END) begin
                  do_retry = 1'b1;
               end else begin
                  tmr_n = tmr + TW'(1);
               end
            end
            S_WCHAN: begin
               if (channel_up_s) begin
                  st_n  = S_STABLE;
                  tmr_n = '0;
               end else if (!lane_up_s || tmr == CT_END) begin
                  do_retry = 1'b1;
               end else begin
                  tmr_n = tmr + TW'(1);
               end
            end
            S_STABLE: begin
               if (!channel_up_s || herr_hit) begin
                  do_retry = 1'b1;
               end else if (tmr == SC_END) begin
                  st_n  = S_UP;
                  tmr_n = '0;
                  rty_n = '0;
               end else begin
                  tmr_n = tmr + TW'(1);
               end
            end
            S_UP: begin
               if (!channel_up_s || herr_hit) do_retry = 1'b1;
            end
            S_FAIL: st_n = S_FAIL;
            default: begin
               st_n  = S_IDLE;
               tmr_n = '0;
            end
         endcase
      end
      if (do_retry) begin
         if (rty == RT_MAX) begin
            st_n = S_FAIL;
         end else begin
            st_n  = S_RESET;
            rty_n = rty + 4'd1;
            tmr_n = '0;
            bump  = 1'b1;
         end
      end
      if (bump && rcnt != 16'hFFFF) rcnt_n = rcnt + 16'd1;
   end

   // Consecutive hard_err run, only meaningful while the channel is qualified.
   always_comb begin
      herr_run_n = '0;
      if ((st == S_STABLE || st == S_UP) && hard_err_s)
         herr_run_n = herr_hit ? herr_run : herr_run + HW'(1);
   end

   // State, counters and the registered output decode of the next state.
   always_ff @(posedge init_clk or negedge aresetn) begin
      if (!aresetn) begin
         st            <= S_IDLE;
         tmr           <= '0;
         rty           <= '0;
         rcnt          <= '0;
         herr_run      <= '0;
         ext_reset_q   <= 1'b1;
         power_down_q  <= 1'b1;
         link_ok_q     <= 1'b0;
         link_failed_q <= 1'b0;
      end else begin
         st            <= st_n;
         tmr           <= tmr_n;
         rty           <= rty_n;
         rcnt          <= rcnt_n;
         herr_run      <= herr_run_n;
         ext_reset_q   <= (st_n == S_IDLE) || (st_n == S_RESET) ||
                          (st_n == S_FAIL);
         power_down_q  <= (st_n == S_IDLE);
         link_ok_q     <= (st_n == S_UP);
         link_failed_q <= (st_n == S_FAIL);
      end
   end

   assign lnk.state       = st;
   assign lnk.retry_count = rty;
   assign lnk.reset_count = rcnt;
   assign lnk.ext_reset   = ext_reset_q;
   assign lnk.power_down  = power_down_q;
   assign lnk.link_ok     = link_ok_q;
   assign lnk.link_failed = link_failed_q;

endmodule
